// File: rtl/register_file_pkg.sv
// Purpose: shared defaults and index/data types for the datapath register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int INDEX_WIDTH = 2;
   localparam int NUM_REGS    = 1 << INDEX_WIDTH;

   typedef logic [INDEX_WIDTH-1:0] reg_index_t;
   typedef logic [DATA_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/register_file_cell.sv
// Purpose: one storage word of the register file, with sync clear and load enable.
// Latency: loads i_d at the rising edge when i_en is high; o_q reflects it after that edge.
// Backpressure: none; a load is always accepted.
module register_cell #(
   parameter int WIDTH = register_file_pkg::DATA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Clear wins over load so a write coincident with reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// Purpose: 2^INDEX_WIDTH x DATA_WIDTH register file, two combinational read ports, one write port.
// Latency: reads are zero-cycle; a write is visible on the read ports one edge later (no bypass).
// Backpressure: none; every write with write_enable high is committed unless reset is asserted.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
   parameter int INDEX_WIDTH = register_file_pkg::INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INDEX_WIDTH-1:0] read_index_a,
   output logic [DATA_WIDTH-1:0]  read_data_a,
   input  logic [INDEX_WIDTH-1:0] read_index_b,
   output logic [DATA_WIDTH-1:0]  read_data_b,
   input  logic [INDEX_WIDTH-1:0] write_index,
   input  logic [DATA_WIDTH-1:0]  write_data,
   input  logic                   write_enable
);

   localparam int LP_NUM_REGS = 1 << INDEX_WIDTH;

   logic [LP_NUM_REGS-1:0] w_write_sel;
   logic [DATA_WIDTH-1:0]  w_cell_q [LP_NUM_REGS];

   // One-hot write decoder; all-zero when no write is requested.
   always_comb begin
      w_write_sel = '0;
      if (write_enable) begin
         w_write_sel[write_index] = 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < LP_NUM_REGS; g++) begin : g_cell
         register_cell #(
            .WIDTH (DATA_WIDTH)
         ) u_cell (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_write_sel[g]),
            .i_d   (write_data),
            .o_q   (w_cell_q[g])
         );
      end
   endgenerate

   // Read muxes take the registered value directly, so a same-index write shows only after the edge.
   assign read_data_a = w_cell_q[read_index_a];
   assign read_data_b = w_cell_q[read_index_b];

endmodule

// File: tb/tb_register_file.sv
// Purpose: directed self-checking bench for register_file.
// Latency: checks reads combinationally and writes one edge after they are driven.
// Backpressure: n/a.
module tb_register_file;
   import register_file_pkg::*;

   logic       clk;
   logic       reset;
   reg_index_t read_index_a;
   reg_data_t  read_data_a;
   reg_index_t read_index_b;
   reg_data_t  read_data_b;
   reg_index_t write_index;
   reg_data_t  write_data;
   logic       write_enable;

   int checks = 0;
   int errors = 0;

   register_file dut (
      .clk          (clk),
      .reset        (reset),
      .read_index_a (read_index_a),
      .read_data_a  (read_data_a),
      .read_index_b (read_index_b),
      .read_data_b  (read_data_b),
      .write_index  (write_index),
      .write_data   (write_data),
      .write_enable (write_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; write_enable = 1'b0; write_index = '0; write_data = '0;
      read_index_a = '0; read_index_b = '0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         read_index_a = reg_index_t'(i);
         read_index_b = reg_index_t'(NUM_REGS - 1 - i);
         #1;
         checks++;
         if (read_data_a !== 16'h0000) begin
            errors++;
            $display("FAIL reset_a idx=%0d got=%h exp=0000", i, read_data_a);
         end
         checks++;
         if (read_data_b !== 16'h0000) begin
            errors++;
            $display("FAIL reset_b idx=%0d got=%h exp=0000", NUM_REGS - 1 - i, read_data_b);
         end
      end
   endtask

   task automatic test_basic_write();
      write_enable = 1'b1; write_index = 2'd0; write_data = 16'd3; read_index_a = 2'd1;
      tick();
      checks++;
      if (read_data_a !== 16'd0) begin
         errors++;
         $display("FAIL basic_reg1_untouched got=%h exp=0000", read_data_a);
      end
      write_index = 2'd1; write_data = 16'd7; read_index_a = 2'd0;
      tick();
      checks++;
      if (read_data_a !== 16'd3) begin
         errors++;
         $display("FAIL basic_reg0 got=%h exp=0003", read_data_a);
      end
      write_enable = 1'b0;
      read_index_a = 2'd1;
      #1;
      checks++;
      if (read_data_a !== 16'd7) begin
         errors++;
         $display("FAIL basic_reg1 got=%h exp=0007", read_data_a);
      end
   endtask

   task automatic test_reset_overrides_write();
      reset = 1'b1; write_enable = 1'b1; write_index = 2'd0; write_data = 16'd10;
      read_index_a = 2'd0; read_index_b = 2'd1;
      tick();
      reset = 1'b0; write_enable = 1'b0;
      #1;
      checks++;
      if (read_data_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_override_reg0 got=%h exp=0000", read_data_a);
      end
      checks++;
      if (read_data_b !== 16'd0) begin
         errors++;
         $display("FAIL reset_override_reg1 got=%h exp=0000", read_data_b);
      end
   endtask

   task automatic test_write_disabled();
      write_enable = 1'b0; write_index = 2'd2; write_data = 16'hBEEF;
      read_index_a = 2'd2; read_index_b = 2'd0;
      tick();
      checks++;
      if (read_data_a !== 16'd0) begin
         errors++;
         $display("FAIL write_disabled_reg2 got=%h exp=0000", read_data_a);
      end
      checks++;
      if (read_data_b !== 16'd0) begin
         errors++;
         $display("FAIL write_disabled_reg0 got=%h exp=0000", read_data_b);
      end
   endtask

   task automatic test_read_during_write();
      write_enable = 1'b1; write_index = 2'd3; write_data = 16'h1111;
      tick();
      write_data = 16'h2222; read_index_a = 2'd3; read_index_b = 2'd3;
      #1;
      checks++;
      if (read_data_a !== 16'h1111) begin
         errors++;
         $display("FAIL rdw_before_a got=%h exp=1111", read_data_a);
      end
      checks++;
      if (read_data_b !== 16'h1111) begin
         errors++;
         $display("FAIL rdw_before_b got=%h exp=1111", read_data_b);
      end
      tick();
      write_enable = 1'b0;
      checks++;
      if (read_data_a !== 16'h2222) begin
         errors++;
         $display("FAIL rdw_after_a got=%h exp=2222", read_data_a);
      end
      checks++;
      if (read_data_b !== 16'h2222) begin
         errors++;
         $display("FAIL rdw_after_b got=%h exp=2222", read_data_b);
      end
   endtask

   task automatic test_full_sweep();
      reg_data_t exp_a;
      reg_data_t exp_b;
      for (int i = 0; i < NUM_REGS; i++) begin
         write_enable = 1'b1;
         write_index  = reg_index_t'(i);
         write_data   = 16'hA000 + reg_data_t'(i);
         tick();
      end
      write_enable = 1'b0;
      // Index-only changes between edges: outputs must follow without a clock.
      @(negedge clk);
      for (int i = 0; i < NUM_REGS; i++) begin
         read_index_a = reg_index_t'(i);
         read_index_b = reg_index_t'(NUM_REGS - 1 - i);
         exp_a = 16'hA000 + reg_data_t'(i);
         exp_b = 16'hA000 + reg_data_t'(NUM_REGS - 1 - i);
         #1;
         checks++;
         if (read_data_a !== exp_a) begin
            errors++;
            $display("FAIL sweep_a idx=%0d got=%h exp=%h", i, read_data_a, exp_a);
         end
         checks++;
         if (read_data_b !== exp_b) begin
            errors++;
            $display("FAIL sweep_b idx=%0d got=%h exp=%h", NUM_REGS - 1 - i, read_data_b, exp_b);
         end
      end
   endtask

   task automatic test_hold();
      reg_data_t exp_a;
      write_enable = 1'b0; write_data = 16'hFFFF;
      for (int i = 0; i < NUM_REGS; i++) begin
         write_index = reg_index_t'(i);
         tick();
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         read_index_a = reg_index_t'(i);
         exp_a = 16'hA000 + reg_data_t'(i);
         #1;
         checks++;
         if (read_data_a !== exp_a) begin
            errors++;
            $display("FAIL hold idx=%0d got=%h exp=%h", i, read_data_a, exp_a);
         end
      end
   endtask

   initial begin
      reset = 1'b0; write_enable = 1'b0; write_index = '0; write_data = '0;
      read_index_a = '0; read_index_b = '0;
      @(negedge clk);
      test_reset();
      test_basic_write();
      test_reset_overrides_write();
      test_write_disabled();
      test_read_during_write();
      test_full_sweep();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
